// File: rtl/reg_bank_ctr.sv
// reg_bank_ctr: DEPTH x WIDTH bank of loadable up/down counters for CPU datapath
// state. One load and one inc/dec may be issued per cycle, to the same or to
// different entries. There are two combinational read ports, and registered
// zero/carry flags report the last valid modify.
module reg_bank_ctr #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             inc,
    input  logic             dec,
    input  logic [AW-1:0]    maddr,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             zero,
    output logic             carry
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             mod_valid;
    logic             load_ok;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             nxt_carry;

    // Addresses at or above DEPTH select no entry.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // Decode the modify op, arbitrate the load against it, and compute the new value.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        cur       = '0;
        nxt       = '0;
        nxt_carry = 1'b0;
        mod_valid = (inc ^ dec) && in_range(maddr);
        // When inc and dec are both high the entry holds, so a load to that same entry is dropped too.
        load_ok   = we && in_range(waddr) &&
                    !((waddr == maddr) && (mod_valid || (inc && dec)));
        if (in_range(maddr)) begin
            cur = mem[maddr];
        end
        if (inc) begin
            if (cur == '1) begin
                nxt       = SAT ? cur : '0;
                nxt_carry = 1'b1;
            end else begin
                nxt = cur + ONE;
            end
        end else begin
            if (cur == '0) begin
                nxt       = SAT ? cur : '1;
                nxt_carry = 1'b1;
            end else begin
                nxt = cur - ONE;
            end
        end
    end

    // Entry and flag state. clr clears everything asynchronously; a valid modify takes priority over a load to the same entry.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            // NOTE: the storage array is reset as well, because the bank must read 0 straight after clr and not power-up garbage.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            zero  <= 1'b0;
            carry <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every entry and flag sample the pre-edge values together.
            for (int i = 0; i < DEPTH; i++) begin
                if (mod_valid && (maddr == AW'(i))) begin
                    mem[i] <= nxt;
                end else if (load_ok && (waddr == AW'(i))) begin
                    mem[i] <= wdata;
                end
            end
            if (mod_valid) begin
                zero  <= (nxt == '0);
                carry <= nxt_carry;
            end
        end
    end

    // Combinational read ports. There is no forwarding, and an out-of-range address reads as zero.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (in_range(raddr_a)) begin
            rdata_a = mem[raddr_a];
        end
        if (in_range(raddr_b)) begin
            rdata_b = mem[raddr_b];
        end
    end

endmodule

// File: tb/tb_reg_bank_ctr.sv
// Bench for reg_bank_ctr. Three instances share one stimulus stream:
//   0: SAT=0, DEPTH=4   1: SAT=1, DEPTH=4   2: SAT=0, DEPTH=3 (AW=2)
// An integer-arithmetic model of the bank is checked against every instance on
// each falling edge. Hand-computed literals pin the model along the way.
module tb_reg_bank_ctr;

    localparam int NI = 3;
    localparam int DEP [NI] = '{4, 4, 3};
    localparam bit SATV [NI] = '{1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       we = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [1:0] waddr = '0, maddr = '0, raddr_a = '0, raddr_b = '0;
    logic [7:0] wdata = '0;

    logic [7:0] ra [NI];
    logic [7:0] rb [NI];
    logic       z  [NI];
    logic       c  [NI];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: plain integers per instance.
    int m  [NI][4];
    int mz [NI];
    int mc [NI];

    reg_bank_ctr #(.WIDTH(8), .DEPTH(4), .AW(2), .SAT(1'b0)) u0 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .inc(inc), .dec(dec), .maddr(maddr),
        .raddr_a(raddr_a), .rdata_a(ra[0]), .raddr_b(raddr_b), .rdata_b(rb[0]),
        .zero(z[0]), .carry(c[0]));

    reg_bank_ctr #(.WIDTH(8), .DEPTH(4), .AW(2), .SAT(1'b1)) u1 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .inc(inc), .dec(dec), .maddr(maddr),
        .raddr_a(raddr_a), .rdata_a(ra[1]), .raddr_b(raddr_b), .rdata_b(rb[1]),
        .zero(z[1]), .carry(c[1]));

    reg_bank_ctr #(.WIDTH(8), .DEPTH(3), .AW(2), .SAT(1'b0)) u2 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .inc(inc), .dec(dec), .maddr(maddr),
        .raddr_a(raddr_a), .rdata_a(ra[2]), .raddr_b(raddr_b), .rdata_b(rb[2]),
        .zero(z[2]), .carry(c[2]));

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_read(input int k, input int a);
        return (a < DEP[k]) ? m[k][a] : 0;
    endfunction

    // Model of the bank: apply the operation rules directly with integer arithmetic.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int k = 0; k < NI; k++) begin
                for (int i = 0; i < 4; i++) m[k][i] = 0;
                mz[k] = 0;
                mc[k] = 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                bit mv;
                bit hold_conflict;
                int v;
                int cv;
                mv = (inc != dec) && (int'(maddr) < DEP[k]);
                hold_conflict = (waddr == maddr) && (mv || (inc && dec));
                if (mv) begin
                    v  = m[k][maddr] + (inc ? 1 : -1);
                    cv = 0;
                    if (v > 255) begin
                        cv = 1;
                        v  = SATV[k] ? 255 : 0;
                    end else if (v < 0) begin
                        cv = 1;
                        v  = SATV[k] ? 0 : 255;
                    end
                    m[k][maddr] = v;
                    mz[k] = (v == 0) ? 1 : 0;
                    mc[k] = cv;
                end
                if (we && (int'(waddr) < DEP[k]) && !hold_conflict) begin
                    m[k][waddr] = int'(wdata);
                end
            end
        end
    end

    // Compare every instance against the model on each falling edge outside reset.
    always @(negedge clk) begin
        if (!clr) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("u%0d rdata_a[%0d]", k, raddr_a), int'(ra[k]), model_read(k, int'(raddr_a)));
                check($sformatf("u%0d rdata_b[%0d]", k, raddr_b), int'(rb[k]), model_read(k, int'(raddr_b)));
                check($sformatf("u%0d zero", k), int'(z[k]), mz[k]);
                check($sformatf("u%0d carry", k), int'(c[k]), mc[k]);
            end
        end
    end

    // Apply one operation for one clock edge, then settle just after the edge.
    task automatic op(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                      input logic i, input logic d, input logic [1:0] ma,
                      input logic [1:0] a, input logic [1:0] b);
        we = w; waddr = wa; wdata = wd; inc = i; dec = d; maddr = ma;
        raddr_a = a; raddr_b = b;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #3;
        for (int k = 0; k < NI; k++) begin
            check("reset rdata_a", int'(ra[k]), 0);
            check("reset zero", int'(z[k]), 0);
            check("reset carry", int'(c[k]), 0);
        end
        #9 clr = 1'b0;
        @(posedge clk);
        #2;

        // Load: visible after the edge, flags untouched.
        op(1'b1, 2'd1, 8'hA5, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
        check("load A5 rdata", int'(ra[0]), 'hA5);
        check("load zero", int'(z[0]), 0);
        check("load carry", int'(c[0]), 0);

        // Wrap and saturate at the top of entry 2.
        op(1'b1, 2'd2, 8'hFF, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0);
        op(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd2, 2'd2, 2'd0);
        check("wrap inc rdata", int'(ra[0]), 'h00);
        check("wrap inc zero", int'(z[0]), 1);
        check("wrap inc carry", int'(c[0]), 1);
        check("sat inc rdata", int'(ra[1]), 'hFF);
        check("sat inc carry", int'(c[1]), 1);

        // inc and dec both high with a load to the same entry: everything holds.
        op(1'b1, 2'd2, 8'h55, 1'b1, 1'b1, 2'd2, 2'd2, 2'd0);
        check("both hold rdata", int'(ra[0]), 'h00);
        check("both hold zero", int'(z[0]), 1);
        check("both hold carry", int'(c[0]), 1);

        op(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0);
        check("wrap dec rdata", int'(ra[0]), 'hFF);
        check("wrap dec zero", int'(z[0]), 0);
        check("wrap dec carry", int'(c[0]), 1);
        check("sat dec FF rdata", int'(ra[1]), 'hFE);
        check("sat dec FF carry", int'(c[1]), 0);

        // Saturating clamp at the bottom of entry 0.
        op(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0);
        check("sat dec rdata", int'(ra[1]), 'h00);
        check("sat dec zero", int'(z[1]), 1);
        check("sat dec carry", int'(c[1]), 1);
        op(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        check("sat inc rdata", int'(ra[1]), 'h01);
        check("sat inc zero", int'(z[1]), 0);
        check("sat inc carry", int'(c[1]), 0);

        // Load and modify in the same cycle.
        op(1'b1, 2'd3, 8'h05, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0);
        op(1'b1, 2'd0, 8'h07, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        op(1'b1, 2'd3, 8'h10, 1'b1, 1'b0, 2'd3, 2'd3, 2'd0);
        check("modify wins rdata", int'(ra[0]), 'h06);
        check("oob read d3", int'(ra[2]), 0);
        check("oob modify zero hold", int'(z[2]), 1);
        check("oob modify carry hold", int'(c[2]), 1);
        op(1'b1, 2'd3, 8'h10, 1'b1, 1'b0, 2'd0, 2'd3, 2'd0);
        check("split load rdata", int'(ra[0]), 'h10);
        check("split inc rdata", int'(rb[0]), 'h08);

        // Out-of-range modify on the DEPTH=3 instance leaves its flags alone.
        op(1'b1, 2'd1, 8'h01, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
        op(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 2'd1, 2'd0);
        check("dec to zero flag", int'(z[2]), 1);
        op(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd3, 2'd3, 2'd0);
        check("d4 inc 3 rdata", int'(ra[0]), 'h11);
        check("d4 inc 3 zero", int'(z[0]), 0);
        check("d3 oob inc zero", int'(z[2]), 1);
        op(1'b1, 2'd3, 8'h77, 1'b0, 1'b0, 2'd0, 2'd3, 2'd2);
        check("d3 oob load read", int'(ra[2]), 0);
        check("d4 load 3", int'(ra[0]), 'h77);

        // Asynchronous clear mid-cycle with entries loaded.
        clr = 1'b1;
        #1;
        for (int a = 0; a < 4; a++) begin
            raddr_a = 2'(a);
            raddr_b = 2'(a);
            #1;
            for (int k = 0; k < NI; k++) begin
                check("clr rdata_a", int'(ra[k]), 0);
                check("clr rdata_b", int'(rb[k]), 0);
                check("clr zero", int'(z[k]), 0);
                check("clr carry", int'(c[k]), 0);
            end
        end
        clr = 1'b0;
        @(posedge clk);
        #2;

        // A mixed stream of operations, checked cycle by cycle against the model.
        for (int n = 0; n < 60; n++) begin
            op(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
               2'($urandom), 2'($urandom), 2'($urandom));
        end
        for (int a = 0; a < 4; a++) begin
            op(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 2'(a), 2'(3 - a));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
